// File: rtl/data_memory_ctrl_pkg.sv
// Shared types and sizing helpers for the word-organised data memory controller.
// Sizing depends on module parameters, so it is exposed as functions.
package data_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic int calcOff(input int dataW);
    return $clog2(dataW / 8);
  endfunction

  function automatic int calcStrbW(input int dataW);
    return dataW / 8;
  endfunction

  function automatic int calcDepth(input int addrW, input int dataW);
    return 2 ** (addrW - calcOff(dataW));
  endfunction

endpackage

// File: rtl/data_memory_ctrl_bank_array.sv
// DEPTH x DATA_W storage with a byte-strobed write port and a combinational read.
// The clear port has priority so a sweep never collides with a normal write.
module dmem_bank_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic                  clk,
  input  logic                  clr_i,
  input  logic [IDX_W-1:0]      clrIdx_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wIdx_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic [IDX_W-1:0]      rIdx_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents deliberately have no reset; only the clear sweep zeroes them.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      mem_q[clrIdx_i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[wIdx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[rIdx_i];

endmodule

// File: rtl/data_memory_ctrl.sv
// Load/store data memory controller: valid/ready requests, one response per
// accepted request after RD_LAT cycles, misalignment errors, optional clear sweep.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int OFF    = calcOff(DATA_W);
  localparam int STRB_W = calcStrbW(DATA_W);
  localparam int DEPTH  = calcDepth(ADDR_W, DATA_W);
  localparam int IDX_W  = ADDR_W - OFF;

  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF) - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [1:0]        LAT_LOAD  = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam state_e            ACC_STATE = (RD_LAT > 1) ? WAIT : RESP;
  localparam state_e            RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : gBadLatency
    $error("data_memory_ctrl: RD_LAT must lie in 1..4");
  end
  if (DATA_W < 8 || (DATA_W % 8) != 0 || (DATA_W & (DATA_W - 1)) != 0) begin : gBadWidth
    $error("data_memory_ctrl: DATA_W must be a power-of-two multiple of 8");
  end

  state_e             state_q;
  logic [IDX_W-1:0]   clrCnt_q;
  logic [1:0]         latCnt_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic               accept;
  logic               misaligned;
  logic [IDX_W-1:0]   wordIdx;
  logic [DATA_W-1:0]  bankRdata;
  logic [STRB_W-1:0]  bankStrb;

  assign misaligned = |(req_addr & OFF_MASK);
  assign wordIdx    = req_addr[ADDR_W-1:OFF];
  assign bankStrb   = req_wstrb;

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign req_ready = rst_n && ((state_q == IDLE) || (state_q == RESP && rsp_ready));
  assign accept    = req_valid && req_ready;

  dmem_bank_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) uBank (
    .clk      (clk),
    .clr_i    ((state_q == CLEAR) && rst_n),
    .clrIdx_i (clrCnt_q),
    .we_i     (accept && req_we && !misaligned),
    .wIdx_i   (wordIdx),
    .wdata_i  (req_wdata),
    .wstrb_i  (bankStrb),
    .rIdx_i   (wordIdx),
    .rdata_o  (bankRdata)
  );

  // Acceptance overrides the per-state transition, which is how a response
  // handshake and a new request share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RST_STATE;
      clrCnt_q <= '0;
      latCnt_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clrCnt_q <= clrCnt_q + 1'b1;
          if (clrCnt_q == LAST_IDX) begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (latCnt_q == 2'd0) begin
            state_q <= RESP;
          end else begin
            latCnt_q <= latCnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready && !accept) begin
            state_q <= IDLE;
          end
        end
        default: ;
      endcase

      if (accept) begin
        state_q  <= ACC_STATE;
        latCnt_q <= LAT_LOAD;
        rdata_q  <= (req_we || misaligned) ? '0 : bankRdata;
        err_q    <= misaligned;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign init_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (RD_LAT=1 and RD_LAT=3) driven by
// directed and random request streams, checked against a word-array model.
module tb_data_memory_ctrl;

  localparam int LAT0  = 1;
  localparam int LAT1  = 3;
  localparam int WORDS = 64;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acceptCyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [1:0]        reqValid = '0;
  logic [1:0]        reqWe = '0;
  logic [1:0][7:0]   reqAddr = '0;
  logic [1:0][31:0]  reqWdata = '0;
  logic [1:0][3:0]   reqWstrb = '0;
  logic [1:0]        rspReady = '1;
  wire  [1:0]        reqReady;
  wire  [1:0]        rspValid;
  wire  [1:0][31:0]  rspRdata;
  wire  [1:0]        rspErr;
  wire  [1:0]        initBusy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [2][WORDS];
  req_t        reqQ[$];
  exp_t        expQ[$];
  exp_t        rspLog[$];

  always #5 clk = ~clk;

  data_memory_ctrl #(
    .ADDR_W(8), .DATA_W(32), .RD_LAT(LAT0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_wstrb(reqWstrb[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]),
    .rsp_err(rspErr[0]), .init_busy(initBusy[0])
  );

  data_memory_ctrl #(
    .ADDR_W(8), .DATA_W(32), .RD_LAT(LAT1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_wstrb(reqWstrb[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]),
    .rsp_err(rspErr[1]), .init_busy(initBusy[1])
  );

  function automatic int latOf(input int u);
    return (u == 0) ? LAT0 : LAT1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pushReq(input bit we, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
    reqQ.push_back(r);
  endtask

  task automatic expectRsp(input string tag, input logic [31:0] rdata, input logic err);
    exp_t e;
    if (rspLog.size() == 0) begin
      checkOutput({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      e = rspLog.pop_front();
      checkOutput({tag, "_rdata"}, e.rdata, rdata);
      checkOutput({tag, "_err"}, 32'(e.err), 32'(err));
    end
  endtask

  // Wait out the clear sweep on both units, counting busy cycles from release.
  task automatic waitClear();
    int cnt [2];
    int rdyWhileBusy;
    bit busyAny;
    cnt[0] = 0; cnt[1] = 0; rdyWhileBusy = 0;
    #1;
    for (int k = 0; k < 200; k++) begin
      busyAny = 1'b0;
      for (int u = 0; u < 2; u++) begin
        if (initBusy[u]) begin
          cnt[u]++;
          busyAny = 1'b1;
          if (reqReady[u]) rdyWhileBusy++;
        end
      end
      if (!busyAny) break;
      @(negedge clk);
      #1;
    end
    checkOutput("u0_clear_cycles", 32'(cnt[0]), 32'(WORDS));
    checkOutput("u1_clear_cycles", 32'(cnt[1]), 32'(WORDS));
    checkOutput("ready_during_clear", 32'(rdyWhileBusy), 32'd0);
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < WORDS; w++) model[u][w] = '0;
  endtask

  // Drains reqQ into unit u; every cycle the expected valid/ready/data come
  // from the model queue. mode 0: rsp_ready high, 1: random, 2: stall first response 5 cycles.
  task automatic applyStimulus(input int u, input int mode, input int budget);
    int   cyc, stall, idx;
    bit   rdy, expValid, expReady, mis;
    req_t r;
    exp_t e;
    cyc = 0; stall = 0;
    while ((reqQ.size() > 0 || expQ.size() > 0) && cyc < budget) begin
      @(negedge clk);
      expValid = (expQ.size() > 0) && (cyc >= expQ[0].acceptCyc + latOf(u));
      case (mode)
        1: rdy = ($urandom_range(3) != 0);
        2: begin
          if (expValid && stall < 5) begin
            rdy = 1'b0;
            stall++;
          end else begin
            rdy = 1'b1;
          end
        end
        default: rdy = 1'b1;
      endcase
      rspReady[u] = rdy;
      if (reqQ.size() > 0 && (mode != 1 || $urandom_range(2) != 0)) begin
        r = reqQ[0];
        reqValid[u] = 1'b1; reqWe[u] = r.we; reqAddr[u] = r.addr;
        reqWdata[u] = r.wdata; reqWstrb[u] = r.wstrb;
      end else begin
        reqValid[u] = 1'b0; reqWe[u] = 1'($urandom); reqAddr[u] = 8'($urandom);
        reqWdata[u] = $urandom; reqWstrb[u] = 4'($urandom);
      end
      #1;
      expReady = (expQ.size() == 0) || (expValid && rdy);
      checkOutput($sformatf("u%0d_rsp_valid", u), 32'(rspValid[u]), 32'(expValid));
      checkOutput($sformatf("u%0d_req_ready", u), 32'(reqReady[u]), 32'(expReady));
      if (expValid) begin
        checkOutput($sformatf("u%0d_rsp_rdata", u), rspRdata[u], expQ[0].rdata);
        checkOutput($sformatf("u%0d_rsp_err", u), 32'(rspErr[u]), 32'(expQ[0].err));
      end
      if (expValid && rdy) begin
        e.rdata = rspRdata[u]; e.err = rspErr[u]; e.acceptCyc = cyc;
        rspLog.push_back(e);
        void'(expQ.pop_front());
      end
      if (reqValid[u] && expReady) begin
        r   = reqQ.pop_front();
        mis = (r.addr % 4) != 0;
        idx = int'(r.addr) / 4;
        e.err = mis;
        e.acceptCyc = cyc;
        if (r.we) begin
          e.rdata = '0;
          if (!mis)
            for (int b = 0; b < 4; b++)
              if (r.wstrb[b]) model[u][idx][b*8 +: 8] = r.wdata[b*8 +: 8];
        end else begin
          e.rdata = mis ? 32'd0 : model[u][idx];
        end
        expQ.push_back(e);
      end
      cyc++;
    end
    reqValid[u] = 1'b0;
    if (reqQ.size() > 0 || expQ.size() > 0) begin
      checkOutput($sformatf("u%0d_timeout", u), 32'(reqQ.size() + expQ.size()), 32'd0);
      reqQ.delete();
      expQ.delete();
    end
  endtask

  task automatic queueRandom(input int n);
    logic [7:0] addr;
    for (int i = 0; i < n; i++) begin
      addr = 8'($urandom_range(15) * 4);
      if ($urandom_range(4) == 0) addr = addr | 8'($urandom_range(3));
      pushReq(1'($urandom), addr, $urandom, 4'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values, then the clear sweep.
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("u%0d_rst_rsp_valid", u), 32'(rspValid[u]), 32'd0);
      checkOutput($sformatf("u%0d_rst_req_ready", u), 32'(reqReady[u]), 32'd0);
      checkOutput($sformatf("u%0d_rst_init_busy", u), 32'(initBusy[u]), 32'd1);
      checkOutput($sformatf("u%0d_rst_rdata", u), rspRdata[u], 32'd0);
      checkOutput($sformatf("u%0d_rst_err", u), 32'(rspErr[u]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waitClear();

    pushReq(1'b0, 8'h10, '0, '0);
    applyStimulus(0, 0, 50);
    expectRsp("clear_read", 32'h0, 1'b0);

    // Byte strobes and misalignment.
    pushReq(1'b1, 8'h20, 32'h11223344, 4'hF);
    pushReq(1'b1, 8'h20, 32'hAABBCCDD, 4'b0010);
    pushReq(1'b0, 8'h20, '0, '0);
    pushReq(1'b0, 8'h21, '0, '0);
    pushReq(1'b1, 8'h22, 32'hFFFFFFFF, 4'hF);
    pushReq(1'b0, 8'h20, '0, '0);
    applyStimulus(0, 0, 100);
    expectRsp("wr_full", 32'h0, 1'b0);
    expectRsp("wr_lane1", 32'h0, 1'b0);
    expectRsp("rd_strb", 32'h1122CC44, 1'b0);
    expectRsp("rd_mis", 32'h0, 1'b1);
    expectRsp("wr_mis", 32'h0, 1'b1);
    expectRsp("rd_after_mis", 32'h1122CC44, 1'b0);

    // Backpressure with a second request waiting on the stalled response.
    pushReq(1'b1, 8'h04, 32'hCAFEF00D, 4'hF);
    applyStimulus(0, 0, 50);
    expectRsp("bp_setup", 32'h0, 1'b0);
    pushReq(1'b0, 8'h20, '0, '0);
    pushReq(1'b0, 8'h04, '0, '0);
    applyStimulus(0, 2, 100);
    expectRsp("bp_first", 32'h1122CC44, 1'b0);
    expectRsp("bp_second", 32'hCAFEF00D, 1'b0);

    // Back-to-back reads on both latencies.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 3; i++) pushReq(1'b1, 8'(i * 4), 32'hA0000000 + 32'(u * 16 + i), 4'hF);
      for (int i = 0; i < 3; i++) pushReq(1'b0, 8'(i * 4), '0, '0);
      applyStimulus(u, 0, 100);
      for (int i = 0; i < 3; i++) expectRsp($sformatf("u%0d_b2b_wr%0d", u, i), 32'h0, 1'b0);
      for (int i = 0; i < 3; i++)
        expectRsp($sformatf("u%0d_b2b_rd%0d", u, i), 32'hA0000000 + 32'(u * 16 + i), 1'b0);
    end

    // Reset while a response is being held.
    @(negedge clk);
    reqValid[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 8'h20; rspReady[0] = 1'b0;
    @(negedge clk);
    reqValid[0] = 1'b0;
    #1;
    checkOutput("mid_rsp_valid", 32'(rspValid[0]), 32'd1);
    checkOutput("mid_rsp_rdata", rspRdata[0], 32'h1122CC44);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rsp_valid", 32'(rspValid[0]), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(reqReady[0]), 32'd0);
    checkOutput("mid_rst_init_busy", 32'(initBusy[0]), 32'd1);
    checkOutput("mid_rst_rdata", rspRdata[0], 32'd0);
    rspReady[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitClear();
    pushReq(1'b0, 8'h20, '0, '0);
    applyStimulus(0, 0, 50);
    expectRsp("post_reset_u0", 32'h0, 1'b0);
    pushReq(1'b0, 8'h04, '0, '0);
    applyStimulus(1, 0, 50);
    expectRsp("post_reset_u1", 32'h0, 1'b0);

    // Random traffic with random valid gaps and backpressure.
    queueRandom(60);
    applyStimulus(0, 1, 2000);
    queueRandom(40);
    applyStimulus(1, 1, 2000);
    rspLog.delete();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the 8-bit single-cycle data memory, serving the core's load/store unit.
- Word-organised storage with byte-lane write strobes and a valid/ready request/response handshake.
- Configurable read latency, misalignment detection, and an optional zero-clear sweep after reset.
- Every accepted request, read or write, returns exactly one response.

Parameters:
- ADDR_W, 8: byte-address width.
- DATA_W, 32: word width in bits; must be a multiple of 8 and a power of two.
- RD_LAT, 1: response latency in cycles after acceptance; legal range 1..4.
- CLEAR_ON_RESET, 1: when 1, zero every word after reset before accepting requests.
- Derived constants: OFF = clog2(DATA_W/8); DEPTH = 2**(ADDR_W-OFF).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte-lane write enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  misaligned access.
- init_busy  out  1  clear sweep in progress.

Behaviour:
- Reset (rst_n low, asynchronous): state = CLEAR if CLEAR_ON_RESET, else IDLE.
  - Outputs during reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, init_busy=CLEAR_ON_RESET.
  - Any in-flight request or pending response is discarded.
  - Array contents are not reset by rst_n.
- States: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Writes word index clr_cnt = 0..DEPTH-1 with zeros, one word per cycle.
  - init_busy=1, req_ready=0.
  - After writing index DEPTH-1, go to IDLE; sweep takes exactly DEPTH cycles.
- Acceptance: occurs on a rising edge where req_valid && req_ready.
  - req_ready = (state==IDLE) || (state==RESP && rsp_ready).
  - A new request may therefore be accepted in the same cycle the previous response handshakes.
- Word index = req_addr[ADDR_W-1:OFF]. Misaligned if req_addr[OFF-1:0] != 0; with OFF=0 there is never misalignment.
- Write, aligned: at the acceptance edge, update lane b iff req_wstrb[b]. Response: rdata=0, err=0.
- Write, misaligned: array untouched. Response: err=1, rdata=0.
- Read, aligned: array word sampled at the acceptance edge into a holding register. Response: err=0.
- Read, misaligned: response rdata=0, err=1.
- Read-after-write: a read accepted any edge after a write's acceptance returns the new data; no extra hazard.
- Latency:
  - RD_LAT=1: go directly to RESP; rsp_valid high in the cycle after acceptance.
  - RD_LAT>1: enter WAIT; a counter runs RD_LAT-1 cycles, then RESP.
  - Write responses use the same latency, so response order always equals request order.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err remain stable until rsp_valid && rsp_ready.
  - On handshake: if a new request is accepted in the same edge, go to WAIT or RESP per RD_LAT; otherwise go to IDLE.
- req_ready is always 0 in WAIT and CLEAR.
- Inputs arriving with req_valid=0 are ignored. req_wstrb is ignored for reads.
- Addresses always fall inside DEPTH by construction; no out-of-range case exists.

Decomposition:
- Package data_mem_pkg:
  - state enum: CLEAR, IDLE, WAIT, RESP.
  - clog2-based helper constants: OFF, DEPTH, STRB_W.
  - Legal RD_LAT range, checked by an elaboration-time assertion.
- Sub-module dmem_bank_array:
  - DEPTH x DATA_W storage.
  - Synchronous byte-strobed write, combinational read.
  - Second write port muxed in for the clear sweep.
- The controller owns the FSM, latency counter, clear counter and response registers.

Test Plan (DATA_W=32, ADDR_W=8, DEPTH=64):
1. Clear after reset: release rst_n -> init_busy=1 and req_ready=0 for exactly 64 cycles. Then read 0x10 -> rdata=0x00000000, err=0.
2. Byte strobes: write 0x11223344 @0x20 with strb=4'hF, then write 0xAABBCCDD @0x20 with strb=4'b0010, then read @0x20 -> rdata=0x1122CC44.
3. Misalignment: read @0x21 -> err=1, rdata=0. Write 0xFFFFFFFF @0x22 with strb=4'hF -> err=1. Read @0x20 -> still 0x1122CC44.
4. Backpressure: hold rsp_ready=0 for 5 cycles during a read response -> rsp_valid, rdata and err stable, req_ready=0. Raise rsp_ready with a pending req_valid -> new request accepted on the same edge.
5. Latency: with RD_LAT=1, response is valid 1 cycle after acceptance; with RD_LAT=3, 3 cycles after. Back-to-back reads of 0x00, 0x04, 0x08 return in order with no dropped responses.
6. Reset mid-operation: drop rst_n while rsp_valid=1 -> rsp_valid=0 immediately. After release, CLEAR runs again, then read @0x20 -> 0x00000000.
